// File: rtl/fpro_bridge_pkg.sv
// -----------------------------------------------------------------------------
// fpro_bridge_pkg
// Shared types and constants for the Avalon-MM to FPro bridge.
//   state_e          : bridge FSM states (IDLE, ISSUE, RWAIT, ACK)
//   RESP_OKAY        : Avalon response code for a decoded access
//   RESP_DECODEERR   : Avalon response code for an access outside the window
//   DEAD_BEEF        : read-data fill returned on a miss when error responses
//                      are enabled (truncated/extended to DATA_W by the user)
//   DEFAULT_BRG_BASE : default bridge window base address
// -----------------------------------------------------------------------------
package fpro_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RWAIT = 2'd2,
        ACK   = 2'd3
    } state_e;

    localparam logic [1:0]  RESP_OKAY        = 2'b00;
    localparam logic [1:0]  RESP_DECODEERR   = 2'b11;
    localparam logic [31:0] DEAD_BEEF        = 32'hDEAD_BEEF;
    localparam logic [31:0] DEFAULT_BRG_BASE = 32'hC000_0000;

endpackage

// File: rtl/fpro_addr_decode.sv
// -----------------------------------------------------------------------------
// fpro_addr_decode
// Purely combinational address decoder for the Avalon-MM to FPro bridge.
// A window hit is address[31:24] == BRG_BASE[31:24]. The region index is the
// CS_W bits directly below the window byte, address[23 -: CS_W], and is only
// decoded onto the one-hot select on a hit. The FPro word address is
// address[ADDR_W+1:2]. ADDR_W + 2 + CS_W must not exceed 24 so that the word
// address never overlaps the region index.
//
// Ports
//   address    in   32      Avalon byte address
//   hit        out  1       address falls inside the bridge window
//   cs         out  N_CS    one-hot region select, all zero on a miss
//   word_addr  out  ADDR_W  FPro word address
// -----------------------------------------------------------------------------
module fpro_addr_decode
    import fpro_bridge_pkg::*;
#(
    parameter logic [31:0] BRG_BASE = DEFAULT_BRG_BASE,
    parameter int unsigned ADDR_W   = 21,
    parameter int unsigned N_CS     = 2,
    localparam int unsigned CS_W    = $clog2(N_CS)
) (
    input  logic [31:0]       address,
    output logic              hit,
    output logic [N_CS-1:0]   cs,
    output logic [ADDR_W-1:0] word_addr
);

    logic [CS_W-1:0] region;
    // Byte-offset bits and any gap bits between word address and region are
    // intentionally ignored; fold them here so the whole bus counts as read.
    logic            unused_addr;

    assign hit         = (address[31:24] == BRG_BASE[31:24]);
    assign region      = address[23 -: CS_W];
    assign word_addr   = address[ADDR_W+1:2];
    assign unused_addr = ^address;

    always_comb begin
        cs = '0;
        if (hit) begin
            cs[region] = 1'b1;
        end
    end

endmodule

// File: rtl/avalon_fpro_bridge_pipe.sv
// -----------------------------------------------------------------------------
// avalon_fpro_bridge_pipe
// Registered Avalon-MM slave to FPro bus bridge. One transaction is in flight
// at a time: IDLE captures the command, ISSUE drives a single-cycle FPro
// strobe, RWAIT waits RD_LAT cycles for FPro read data, ACK drops waitrequest
// for one cycle. Accesses outside the window complete without any FPro strobe.
//
// Optional feature macro: AVALON_FPRO_ERR_RESP_EN
//   defined   : response port present; a miss returns RESP_DECODEERR with
//               DEAD_BEEF read data, a hit returns RESP_OKAY.
//   undefined : no response port; a miss returns zero read data.
//
// Ports
//   clk, reset          in   1         clock, asynchronous active-high reset
//   read, write         in   1         Avalon command (never both high)
//   chipselect          in   1         Avalon slave select
//   address             in   32        Avalon byte address
//   byteenable          in   DATA_W/8  write byte lanes
//   writedata           in   DATA_W    write data
//   readdata            out  DATA_W    read data, held until next read
//   waitrequest         out  1         Avalon stall
//   response            out  2         OKAY / DECODEERROR (optional)
//   clk_out, reset_out  out  1         clock / reset pass-throughs
//   fp_rd_data          in   DATA_W    FPro read data
//   fp_wr_data          out  DATA_W    byte-masked write data (registered)
//   fp_addr             out  ADDR_W    FPro word address (registered)
//   fp_be               out  DATA_W/8  byte enables (registered)
//   fp_wr, fp_rd        out  1         one-cycle strobes (registered)
//   fp_cs               out  N_CS      one-hot region select (registered)
// -----------------------------------------------------------------------------
module avalon_fpro_bridge_pipe
    import fpro_bridge_pkg::*;
#(
    parameter logic [31:0] BRG_BASE = DEFAULT_BRG_BASE,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 21,
    parameter int unsigned N_CS     = 2,
    parameter int unsigned RD_LAT   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  read,
    input  logic                  write,
    input  logic                  chipselect,
    input  logic [31:0]           address,
    input  logic [DATA_W/8-1:0]   byteenable,
    input  logic [DATA_W-1:0]     writedata,
    output logic [DATA_W-1:0]     readdata,
    output logic                  waitrequest,
`ifdef AVALON_FPRO_ERR_RESP_EN
    output logic [1:0]            response,
`endif
    output logic                  clk_out,
    output logic                  reset_out,
    input  logic [DATA_W-1:0]     fp_rd_data,
    output logic [DATA_W-1:0]     fp_wr_data,
    output logic [ADDR_W-1:0]     fp_addr,
    output logic [DATA_W/8-1:0]   fp_be,
    output logic                  fp_wr,
    output logic                  fp_rd,
    output logic [N_CS-1:0]       fp_cs
);

    localparam int unsigned BE_W        = DATA_W / 8;
    localparam logic [2:0]  LAT_CNT_END = 3'(RD_LAT);

`ifdef AVALON_FPRO_ERR_RESP_EN
    localparam logic [DATA_W-1:0] MISS_FILL = DATA_W'(DEAD_BEEF);
`else
    localparam logic [DATA_W-1:0] MISS_FILL = '0;
`endif

    state_e              state_q, state_d;
    logic                cmd;
    logic                accept;
    logic                done;
    logic                sample_rd;
    logic                hit_q;
    logic                rd_q;
    logic [2:0]          lat_cnt_q;

    logic                dec_hit;
    logic [N_CS-1:0]     dec_cs;
    logic [ADDR_W-1:0]   dec_word;
    logic [DATA_W-1:0]   masked_wdata;

    assign clk_out   = clk;
    assign reset_out = reset;
    assign cmd       = chipselect & (read | write);

    fpro_addr_decode #(
        .BRG_BASE (BRG_BASE),
        .ADDR_W   (ADDR_W),
        .N_CS     (N_CS)
    ) u_decode (
        .address   (address),
        .hit       (dec_hit),
        .cs        (dec_cs),
        .word_addr (dec_word)
    );

    always_comb begin
        masked_wdata = '0;
        for (int i = 0; i < BE_W; i++) begin
            if (byteenable[i]) begin
                masked_wdata[8*i +: 8] = writedata[8*i +: 8];
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the sequence runs to completion even if the master
    // drops its command mid-transaction.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cmd) state_d = ISSUE;
            ISSUE:   state_d = (rd_q && RD_LAT != 0) ? RWAIT : ACK;
            RWAIT:   if (lat_cnt_q == LAT_CNT_END) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        done        = (state_q == ACK);
        accept      = (state_q == IDLE) & cmd;
        waitrequest = cmd & ~done;
        // Read data is taken in the strobe cycle itself when RD_LAT is 0,
        // otherwise in the RWAIT cycle where the counter reaches RD_LAT.
        sample_rd   = rd_q & (((state_q == ISSUE) && (RD_LAT == 0)) ||
                              ((state_q == RWAIT) && (lat_cnt_q == LAT_CNT_END)));
    end

    // Datapath and registered FPro outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_q      <= 1'b0;
            rd_q       <= 1'b0;
            lat_cnt_q  <= '0;
            readdata   <= '0;
            fp_wr_data <= '0;
            fp_addr    <= '0;
            fp_be      <= '0;
            fp_wr      <= 1'b0;
            fp_rd      <= 1'b0;
            fp_cs      <= '0;
        end else begin
            // Strobes are set on acceptance so they are high exactly in ISSUE.
            if (accept) begin
                hit_q <= dec_hit;
                rd_q  <= read;
                fp_rd <= dec_hit & read;
                fp_wr <= dec_hit & write;
                fp_cs <= dec_cs;
                // Address/data only move when a strobe goes out, so the FPro
                // side always shows the last access it actually saw.
                if (dec_hit) begin
                    fp_addr    <= dec_word;
                    fp_wr_data <= masked_wdata;
                    fp_be      <= byteenable;
                end
            end else begin
                fp_rd <= 1'b0;
                fp_wr <= 1'b0;
                fp_cs <= '0;
            end

            // Counter is 1 in the first RWAIT cycle, so it equals RD_LAT in
            // cycle 1+RD_LAT after the strobe.
            if (state_d == RWAIT) begin
                lat_cnt_q <= lat_cnt_q + 3'd1;
            end else begin
                lat_cnt_q <= '0;
            end

            if (sample_rd) begin
                readdata <= hit_q ? fp_rd_data : MISS_FILL;
            end
        end
    end

`ifdef AVALON_FPRO_ERR_RESP_EN
    // Response is updated as the transaction enters ACK and held afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            response <= RESP_OKAY;
        end else if ((state_d == ACK) && (state_q != ACK)) begin
            response <= hit_q ? RESP_OKAY : RESP_DECODEERR;
        end
    end
`endif

endmodule

// File: tb/tb_avalon_fpro_bridge_pipe.sv
// -----------------------------------------------------------------------------
// tb_avalon_fpro_bridge_pipe
// Four bridge instances share the Avalon/FPro inputs but have separate
// chipselects:  inst0 N_CS=2 RD_LAT=1, inst1 N_CS=4 RD_LAT=0,
//               inst2 N_CS=4 RD_LAT=3, inst3 N_CS=4 RD_LAT=7.
// Expected cycle behaviour comes from the timing rules (strobe in cycle 1,
// completion in cycle 2 or 2+RD_LAT) and from arithmetic on the address.
// -----------------------------------------------------------------------------
module tb_avalon_fpro_bridge_pipe;

    localparam int NI = 4;

`ifdef AVALON_FPRO_ERR_RESP_EN
    localparam logic [31:0] FILL = 32'hDEAD_BEEF;
`else
    localparam logic [31:0] FILL = 32'h0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          read = 1'b0;
    logic          write = 1'b0;
    logic [NI-1:0] csel = '0;
    logic [31:0]   address = '0;
    logic [31:0]   writedata = '0;
    logic [3:0]    byteenable = '0;
    logic [31:0]   fp_rd_data = '0;

    logic [NI-1:0] wreq, fpwr, fprd, clko, rsto;
    logic [3:0]    fpcs   [NI];
    logic [3:0]    fpbe   [NI];
    logic [20:0]   fpaddr [NI];
    logic [31:0]   fpwd   [NI];
    logic [31:0]   rdata  [NI];
`ifdef AVALON_FPRO_ERR_RESP_EN
    logic [1:0]    resp   [NI];
`endif

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned NCS = (g == 0) ? 2 : 4;
        localparam int unsigned AW  = (g == 0) ? 21 : 20;
        localparam int unsigned LAT = (g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 3 : 7;
        logic [NCS-1:0] cs_o;
        logic [AW-1:0]  addr_o;

        avalon_fpro_bridge_pipe #(
            .BRG_BASE (32'hC000_0000),
            .DATA_W   (32),
            .ADDR_W   (AW),
            .N_CS     (NCS),
            .RD_LAT   (LAT)
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .read        (read),
            .write       (write),
            .chipselect  (csel[g]),
            .address     (address),
            .byteenable  (byteenable),
            .writedata   (writedata),
            .readdata    (rdata[g]),
            .waitrequest (wreq[g]),
`ifdef AVALON_FPRO_ERR_RESP_EN
            .response    (resp[g]),
`endif
            .clk_out     (clko[g]),
            .reset_out   (rsto[g]),
            .fp_rd_data  (fp_rd_data),
            .fp_wr_data  (fpwd[g]),
            .fp_addr     (addr_o),
            .fp_be       (fpbe[g]),
            .fp_wr       (fpwr[g]),
            .fp_rd       (fprd[g]),
            .fp_cs       (cs_o)
        );

        assign fpcs[g]   = 4'(cs_o);
        assign fpaddr[g] = 21'(addr_o);
    end

    int errors = 0;
    int checks = 0;
    logic [31:0] mrd [NI];   // model: readdata each instance should hold

    typedef struct {
        int          k;
        bit          wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        logic [3:0]  ecs;
        logic [20:0] eaddr;
        logic [31:0] ewd;
    } vec_t;

    vec_t vecs [10];

    function automatic int lat_of(input int k);
        case (k)
            0:       return 1;
            1:       return 0;
            2:       return 3;
            default: return 7;
        endcase
    endfunction

    function automatic int ncs_of(input int k);
        return (k == 0) ? 2 : 4;
    endfunction

    function automatic int aw_of(input int k);
        return (k == 0) ? 21 : 20;
    endfunction

    function automatic logic [3:0] exp_cs(input int k, input logic [31:0] a);
        int csw = (ncs_of(k) == 2) ? 1 : 2;
        int idx;
        if (a[31:24] != 8'hC0) return 4'h0;
        idx = int'((a >> (24 - csw))) & (ncs_of(k) - 1);
        return 4'(1 << idx);
    endfunction

    function automatic logic [20:0] exp_addr(input int k, input logic [31:0] a);
        return 21'((a >> 2) & ((32'd1 << aw_of(k)) - 1));
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [31:0] d, input logic [3:0] be);
        logic [31:0] r = '0;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

    task automatic chk(input string what, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d t=%0t: got %h, expected %h", what, k, $time, act, exp);
        end
    endtask

    // Called at #1 after a posedge (cycle 0). Returns at #1 into the cycle
    // after completion with the command removed, so calls chain back-to-back.
    task automatic txn(input int k, input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic [3:0] ecs, input logic [20:0] eaddr,
                       input logic [31:0] ewd);
        int          lat = lat_of(k);
        int          dn = wr ? 2 : 2 + lat;
        bit          hit = (ecs != 4'h0);
        logic [31:0] sampled = '0;
        csel       = '0;
        csel[k]    = 1'b1;
        read       = !wr;
        write      = wr;
        address    = a;
        writedata  = d;
        byteenable = be;
        for (int n = 0; n <= dn; n++) begin
            fp_rd_data = $urandom;   // fresh every cycle: stale samples show up
            if (n == 1 + lat) sampled = fp_rd_data;
            @(negedge clk);
            chk("waitrequest", k, 32'(wreq[k]), 32'(n != dn));
            chk("fp_wr", k, 32'(fpwr[k]), 32'(n == 1 && wr && hit));
            chk("fp_rd", k, 32'(fprd[k]), 32'(n == 1 && !wr && hit));
            chk("fp_cs", k, 32'(fpcs[k]), (n == 1) ? 32'(ecs) : 32'h0);
            if (n == 1 && hit) begin
                chk("fp_addr", k, 32'(fpaddr[k]), 32'(eaddr));
                if (wr) begin
                    chk("fp_be", k, 32'(fpbe[k]), 32'(be));
                    chk("fp_wr_data", k, fpwd[k], ewd);
                end
            end
            if (n == dn) begin
                if (!wr) mrd[k] = hit ? sampled : FILL;
                chk("readdata", k, rdata[k], mrd[k]);
`ifdef AVALON_FPRO_ERR_RESP_EN
                chk("response", k, 32'(resp[k]), hit ? 32'h0 : 32'h3);
`endif
            end
            @(posedge clk);
            #1;
        end
        csel  = '0;
        read  = 1'b0;
        write = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < NI; k++) mrd[k] = '0;

        vecs[0] = '{0, 1'b1, 32'hC000_0010, 32'h1234_5678, 4'b0101, 4'b0001, 21'd4, 32'h0034_0078};
        vecs[1] = '{0, 1'b0, 32'hC080_0008, 32'h0, 4'hF, 4'b0010, 21'd2, 32'h0};
        vecs[2] = '{1, 1'b0, 32'hC000_0004, 32'h0, 4'hF, 4'b0001, 21'd1, 32'h0};
        vecs[3] = '{2, 1'b1, 32'hC040_0000, 32'hAABB_CCDD, 4'b1010, 4'b0010, 21'd0, 32'hAA00_CC00};
        vecs[4] = '{2, 1'b0, 32'hC040_0000, 32'h0, 4'hF, 4'b0010, 21'd0, 32'h0};
        vecs[5] = '{3, 1'b0, 32'hC0C0_000C, 32'h0, 4'hF, 4'b1000, 21'd3, 32'h0};
        vecs[6] = '{0, 1'b0, 32'h8000_0000, 32'h0, 4'hF, 4'b0000, 21'd0, 32'h0};
        vecs[7] = '{1, 1'b1, 32'h7000_0040, 32'hFFFF_FFFF, 4'hF, 4'b0000, 21'd0, 32'h0};
        vecs[8] = '{2, 1'b0, 32'hC080_0100, 32'h0, 4'hF, 4'b0100, 21'h40, 32'h0};
        vecs[9] = '{0, 1'b1, 32'hC0FF_FFFC, 32'hDEAD_C0DE, 4'b1000, 4'b0010, 21'h1F_FFFF,
                    32'hDE00_0000};

        // Reset state, with a command present on every instance.
        csel    = '1;
        read    = 1'b1;
        address = 32'hC000_0000;
        #23;
        for (int k = 0; k < NI; k++) begin
            chk("rst waitrequest", k, 32'(wreq[k]), 32'h1);
            chk("rst fp_wr", k, 32'(fpwr[k]), 32'h0);
            chk("rst fp_rd", k, 32'(fprd[k]), 32'h0);
            chk("rst fp_cs", k, 32'(fpcs[k]), 32'h0);
            chk("rst readdata", k, rdata[k], 32'h0);
            chk("rst reset_out", k, 32'(rsto[k]), 32'h1);
        end
        csel = '0;
        read = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Directed table; entries 3 and 4 run back-to-back on the same instance.
        for (int i = 0; i < 10; i++) begin
            txn(vecs[i].k, vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].be, vecs[i].ecs,
                vecs[i].eaddr, vecs[i].ewd);
        end

        // Command dropped after acceptance: one strobe only, sequence completes.
        fp_rd_data = 32'h5555_AAAA;
        csel[2]    = 1'b1;
        read       = 1'b1;
        address    = 32'hC000_0008;
        @(posedge clk);
        #1;
        csel = '0;
        read = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            chk("drop fp_rd", 2, 32'(fprd[2]), 32'(n == 1));
            chk("drop waitrequest", 2, 32'(wreq[2]), 32'h0);
            @(posedge clk);
            #1;
        end
        mrd[2] = 32'h5555_AAAA;
        chk("drop readdata", 2, rdata[2], mrd[2]);
        txn(2, 1'b0, 32'hC000_000C, 32'h0, 4'hF, 4'b0001, 21'd3, 32'h0);

        // Asynchronous reset while a write is in ISSUE.
        csel[0]    = 1'b1;
        write      = 1'b1;
        address    = 32'hC000_0020;
        writedata  = 32'h0BAD_F00D;
        byteenable = 4'hF;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("pre-reset fp_wr", 0, 32'(fpwr[0]), 32'h1);
        #1 reset = 1'b1;
        #1;
        chk("async fp_wr", 0, 32'(fpwr[0]), 32'h0);
        chk("async fp_cs", 0, 32'(fpcs[0]), 32'h0);
        chk("async fp_addr", 0, 32'(fpaddr[0]), 32'h0);
        chk("async fp_wr_data", 0, fpwd[0], 32'h0);
        chk("async fp_be", 0, 32'(fpbe[0]), 32'h0);
        chk("async readdata", 0, rdata[0], 32'h0);
        chk("async waitrequest", 0, 32'(wreq[0]), 32'h1);
        @(negedge clk);
        reset = 1'b0;
        csel  = '0;
        write = 1'b0;
        for (int k = 0; k < NI; k++) mrd[k] = '0;
        @(posedge clk);
        #1;
        txn(0, 1'b1, 32'hC000_0020, 32'h0BAD_F00D, 4'hF, 4'b0001, 21'h8, 32'h0BAD_F00D);

        // Randomized traffic against the address/lane/latency model.
        for (int i = 0; i < 60; i++) begin
            int          k = int'($urandom_range(0, NI - 1));
            bit          wr = 1'($urandom_range(0, 1));
            logic [31:0] a;
            logic [31:0] d = $urandom;
            logic [3:0]  be = 4'($urandom);
            a = {($urandom_range(0, 4) == 0) ? 8'h5A : 8'hC0, 24'($urandom)};
            txn(k, wr, a, d, be, exp_cs(k, a), exp_addr(k, a), exp_wdata(d, be));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
